alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 132 +++++++++++++
 tb/tb_alu_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational 10-bit add/subtract ALU.
// Each accepted operation takes one execute cycle, then its result is held until the consumer takes it.
module alu_arbiter #(
  parameter int FIXED_PRIORITY = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic       req0_op,
  input  logic [9:0] req0_a,
  input  logic [9:0] req0_b,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic       req1_op,
  input  logic [9:0] req1_a,
  input  logic [9:0] req1_b,
  output logic       req1_ready,
  output logic       alu_ctrl,
  output logic [9:0] alu_a,
  output logic [9:0] alu_b,
  input  logic [9:0] alu_result,
  output logic       rsp_valid,
  output logic       rsp_id,
  output logic [9:0] rsp_data,
  input  logic       rsp_ready,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state_r;
  state_t     state_s;
  logic       grant_s;
  logic       grant_id_s;
  logic       last_grant_r;
  logic       op_r;
  logic [9:0] a_r;
  logic [9:0] b_r;
  logic       rsp_id_r;
  logic [9:0] rsp_data_r;

  // Grant decision: only in IDLE, never to a deasserted valid.
  always_comb begin
    grant_s    = 1'b0;
    grant_id_s = 1'b0;
    if (state_r == IDLE) begin
      if (req0_valid && req1_valid) begin
        grant_s = 1'b1;
        if (FIXED_PRIORITY != 32'sd0) begin
          grant_id_s = 1'b0;
        end else begin
          grant_id_s = ~last_grant_r;
        end
      end else if (req0_valid) begin
        grant_s    = 1'b1;
        grant_id_s = 1'b0;
      end else if (req1_valid) begin
        grant_s    = 1'b1;
        grant_id_s = 1'b1;
      end else begin
        grant_s    = 1'b0;
        grant_id_s = 1'b0;
      end
    end else begin
      grant_s    = 1'b0;
      grant_id_s = 1'b0;
    end
  end

  // Next-state logic for the IDLE -> EXEC -> RESP sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_s) begin
          state_s = EXEC;
        end else begin
          state_s = IDLE;
        end
      end
      EXEC: state_s = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State, operand latch, grant pointer and result capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b1;
      op_r         <= 1'b0;
      a_r          <= 10'd0;
      b_r          <= 10'd0;
      rsp_id_r     <= 1'b0;
      rsp_data_r   <= 10'd0;
    end else begin
      state_r <= state_s;
      if (grant_s) begin
        last_grant_r <= grant_id_s;
        rsp_id_r     <= grant_id_s;
        op_r         <= grant_id_s ? req1_op : req0_op;
        a_r          <= grant_id_s ? req1_a : req0_a;
        b_r          <= grant_id_s ? req1_b : req0_b;
      end
      if (state_r == EXEC) begin
        rsp_data_r <= alu_result;
      end
    end
  end

  assign req0_ready = grant_s & ~grant_id_s;
  assign req1_ready = grant_s & grant_id_s;
  assign alu_ctrl   = op_r;
  assign alu_a      = a_r;
  assign alu_b      = b_r;
  assign rsp_valid  = (state_r == RESP);
  assign rsp_id     = rsp_id_r;
  assign rsp_data   = rsp_data_r;
  assign busy       = (state_r != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench: a round-robin instance and a fixed-priority instance share one stimulus stream;
// a transaction-level model predicts grants and results, a monitor checks responses from queues.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       v0 = 1'b0, op0 = 1'b0, v1 = 1'b0, op1 = 1'b0, rsp_rdy = 1'b0;
  logic [9:0] a0 = 10'd0, b0 = 10'd0, a1 = 10'd0, b1 = 10'd0;

  logic [1:0] rdy0, rdy1, ctrl, rv, rid, bsy;
  logic [9:0] alu_a [2];
  logic [9:0] alu_b [2];
  logic [9:0] alu_res [2];
  logic [9:0] rdata [2];

  int checks = 0;
  int errors = 0;

  // transaction model state, per instance (0 = round robin, 1 = fixed priority)
  int         ph [2];
  logic       last [2];
  logic       mop [2];
  logic [9:0] ma [2];
  logic [9:0] mb [2];
  logic [1:0] acc_rr;
  logic [10:0] q0 [$];
  logic [10:0] q1 [$];
  logic       lg0 [$];
  logic       lg1 [$];

  always #5 clk = ~clk;

  // external shared ALU for each instance
  assign alu_res[0] = ctrl[0] ? alu_a[0] - alu_b[0] : alu_a[0] + alu_b[0];
  assign alu_res[1] = ctrl[1] ? alu_a[1] - alu_b[1] : alu_a[1] + alu_b[1];

  alu_arbiter #(.FIXED_PRIORITY(0)) u_rr (
    .clk(clk), .reset(reset),
    .req0_valid(v0), .req0_op(op0), .req0_a(a0), .req0_b(b0), .req0_ready(rdy0[0]),
    .req1_valid(v1), .req1_op(op1), .req1_a(a1), .req1_b(b1), .req1_ready(rdy1[0]),
    .alu_ctrl(ctrl[0]), .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_result(alu_res[0]),
    .rsp_valid(rv[0]), .rsp_id(rid[0]), .rsp_data(rdata[0]), .rsp_ready(rsp_rdy), .busy(bsy[0])
  );

  alu_arbiter #(.FIXED_PRIORITY(1)) u_fp (
    .clk(clk), .reset(reset),
    .req0_valid(v0), .req0_op(op0), .req0_a(a0), .req0_b(b0), .req0_ready(rdy0[1]),
    .req1_valid(v1), .req1_op(op1), .req1_a(a1), .req1_b(b1), .req1_ready(rdy1[1]),
    .alu_ctrl(ctrl[1]), .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_result(alu_res[1]),
    .rsp_valid(rv[1]), .rsp_id(rid[1]), .rsp_data(rdata[1]), .rsp_ready(rsp_rdy), .busy(bsy[1])
  );

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] actual=%0h expected=%0h at %0t", name, k, act, exp, $time);
    end
  endtask

  // one transaction-level step of the model for instance k, using the inputs of this cycle
  task automatic model_step(input int k);
    logic e0, e1, g;
    logic [9:0] d;
    e0 = 1'b0;
    e1 = 1'b0;
    g  = 1'b0;
    if (ph[k] == 0) begin
      chk("busy_idle", k, bsy[k], 1'b0);
      chk("rv_idle", k, rv[k], 1'b0);
      if (v0 || v1) begin
        if (v0 && v1) g = (k == 1) ? 1'b0 : ~last[k];
        else          g = v1;
        e0 = ~g;
        e1 = g;
        last[k] = g;
        mop[k] = g ? op1 : op0;
        ma[k]  = g ? a1 : a0;
        mb[k]  = g ? b1 : b0;
        d = mop[k] ? 10'((int'(ma[k]) - int'(mb[k])) % 1024) : 10'((int'(ma[k]) + int'(mb[k])) % 1024);
        if (k == 0) begin q0.push_back({g, d}); acc_rr[g] = 1'b1; end
        else        q1.push_back({g, d});
        ph[k] = 1;
      end
    end else if (ph[k] == 1) begin
      chk("busy_exec", k, bsy[k], 1'b1);
      chk("rv_exec", k, rv[k], 1'b0);
      chk("alu_ctrl", k, ctrl[k], mop[k]);
      chk("alu_a", k, alu_a[k], ma[k]);
      chk("alu_b", k, alu_b[k], mb[k]);
      ph[k] = 2;
    end else begin
      chk("busy_resp", k, bsy[k], 1'b1);
      chk("rv_resp", k, rv[k], 1'b1);
      if (rsp_rdy) ph[k] = 0;
    end
    chk("ready0", k, rdy0[k], e0);
    chk("ready1", k, rdy1[k], e1);
  endtask

  task automatic tick();
    @(negedge clk);
    acc_rr = 2'b00;
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      ph[k] = 0; last[k] = 1'b1; mop[k] = 1'b0; ma[k] = 10'd0; mb[k] = 10'd0;
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk({tag, "_rv"}, k, rv[k], 1'b0);
      chk({tag, "_busy"}, k, bsy[k], 1'b0);
      chk({tag, "_rid"}, k, rid[k], 1'b0);
      chk({tag, "_rdata"}, k, rdata[k], 10'd0);
      chk({tag, "_ctrl"}, k, ctrl[k], 1'b0);
      chk({tag, "_alu_a"}, k, alu_a[k], 10'd0);
      chk({tag, "_alu_b"}, k, alu_b[k], 10'd0);
    end
  endtask

  task automatic mon(input int k);
    logic [10:0] ent;
    if (rv[k]) begin
      if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp[%0d] actual=rsp_valid expected=none at %0t", k, $time);
      end else begin
        ent = (k == 0) ? q0[0] : q1[0];
        chk("rsp_id", k, rid[k], ent[10]);
        chk("rsp_data", k, rdata[k], ent[9:0]);
        if (rsp_rdy) begin
          if (k == 0) begin void'(q0.pop_front()); lg0.push_back(rid[0]); end
          else        begin void'(q1.pop_front()); lg1.push_back(rid[1]); end
        end
      end
    end
  endtask

  // response monitor, decoupled from stimulus
  always @(negedge clk) begin
    if (!reset) begin
      mon(0);
      mon(1);
    end
  end

  initial begin
    logic exp_fp [$];
    model_reset();
    acc_rr = 2'b00;
    #1;
    check_reset_outputs("por");
    @(posedge clk);
    #1;
    reset = 1'b0;
    rsp_rdy = 1'b1;

    // contention, round robin: both held high, expect 0,1,0,1
    v0 = 1'b1; op0 = 1'b0; a0 = 10'h011; b0 = 10'h022;
    v1 = 1'b1; op1 = 1'b1; a1 = 10'h100; b1 = 10'h001;
    lg0.delete(); lg1.delete();
    repeat (12) tick();
    v0 = 1'b0; v1 = 1'b0;
    repeat (3) tick();
    chk("rr_order_len", 0, lg0.size(), 4);
    for (int i = 0; i < 4 && i < lg0.size(); i++) chk("rr_order", i, lg0[i], i % 2);

    // single add from requester 0
    v0 = 1'b1; op0 = 1'b0; a0 = 10'h0D7; b0 = 10'h02E;
    #1;
    chk("add_ready", 0, rdy0[0], 1'b1);
    tick();
    v0 = 1'b0;
    tick();
    chk("add_rv", 0, rv[0], 1'b1);
    chk("add_rid", 0, rid[0], 1'b0);
    chk("add_data", 0, rdata[0], 10'h105);
    tick();

    // subtract with wrap from requester 1
    v1 = 1'b1; op1 = 1'b1; a1 = 10'h2AA; b1 = 10'h33E;
    tick();
    v1 = 1'b0;
    tick();
    chk("sub_rv", 0, rv[0], 1'b1);
    chk("sub_rid", 0, rid[0], 1'b1);
    chk("sub_data", 0, rdata[0], 10'h36C);
    tick();

    // backpressure: 5 cycles held in RESP while requests wait
    rsp_rdy = 1'b0;
    v0 = 1'b1; op0 = 1'b1; a0 = 10'h005; b0 = 10'h009;
    tick();
    v0 = 1'b0;
    tick();
    v0 = 1'b1; v1 = 1'b1; a0 = 10'h3FF; b0 = 10'h001; op0 = 1'b0;
    repeat (5) tick();
    rsp_rdy = 1'b1;
    tick();
    chk("bp_release_busy", 0, bsy[0], 1'b0);
    v0 = 1'b0; v1 = 1'b0;
    repeat (6) tick();

    // reset while in EXEC discards the in-flight result
    v0 = 1'b1; op0 = 1'b0; a0 = 10'h123; b0 = 10'h111;
    tick();
    v0 = 1'b0;
    reset = 1'b1;
    #1;
    check_reset_outputs("mid");
    model_reset();
    tick();
    check_reset_outputs("hold");
    reset = 1'b0;
    v1 = 1'b1; op1 = 1'b0; a1 = 10'h200; b1 = 10'h1FF;
    tick();
    v1 = 1'b0;
    repeat (3) tick();

    // fixed priority: requester 0 wins while valid, requester 1 after it drops
    lg1.delete();
    v0 = 1'b1; op0 = 1'b0; a0 = 10'h001; b0 = 10'h002;
    v1 = 1'b1; op1 = 1'b0; a1 = 10'h010; b1 = 10'h020;
    repeat (9) tick();
    v0 = 1'b0;
    repeat (3) tick();
    v1 = 1'b0;
    repeat (3) tick();
    exp_fp = '{1'b0, 1'b0, 1'b0, 1'b1};
    chk("fp_order_len", 1, lg1.size(), 4);
    for (int i = 0; i < 4 && i < lg1.size(); i++) chk("fp_order", i, lg1[i], exp_fp[i]);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      if (acc_rr[0] || !v0 || $urandom_range(0, 5) == 0) begin
        v0 = ($urandom_range(0, 3) != 0); op0 = 1'($urandom);
        a0 = 10'($urandom); b0 = 10'($urandom);
      end
      if (acc_rr[1] || !v1 || $urandom_range(0, 5) == 0) begin
        v1 = ($urandom_range(0, 3) != 0); op1 = 1'($urandom);
        a1 = 10'($urandom); b1 = 10'($urandom);
      end
      rsp_rdy = ($urandom_range(0, 3) != 0);
      tick();
    end

    // drain
    v0 = 1'b0; v1 = 1'b0; rsp_rdy = 1'b1;
    repeat (5) tick();
    chk("drain_q", 0, q0.size(), 0);
    chk("drain_q", 1, q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
